dbg_module_ctrl: RTL and testbench

Debug Module controller for the rv32i core. It is the external-debugger side of the core's halt/resume and abstract-register-access interface. It decodes DMI register reads and writes for dmcontrol, dmstatus, abstractcs, command and data0. It drives dbg_haltreq/dbg_resumereq and sequences Access Register commands over dbg_ar_*, returning results through data0.

---
 rtl/dbg_module_ctrl.sv | 147 ++++++++++++++
 tb/tb_dbg_module_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_module_ctrl.sv
// dbg_module_ctrl: RISC-V debug module front end for halt/resume and abstract register access
module dbg_module_ctrl #(
  parameter int AR_TIMEOUT = 16,
  parameter int DMI_AW     = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dmi_req_valid,
  output logic              dmi_req_ready,
  input  logic [DMI_AW-1:0] dmi_req_addr,
  input  logic [1:0]        dmi_req_op,
  input  logic [31:0]       dmi_req_data,
  output logic              dmi_rsp_valid,
  output logic [31:0]       dmi_rsp_data,
  output logic              dbg_haltreq,
  output logic              dbg_resumereq,
  input  logic              core_resumeack,
  input  logic              core_running,
  input  logic              core_halted,
  output logic              dbg_ar_en,
  output logic              dbg_ar_wr,
  output logic [15:0]       dbg_ar_ad,
  output logic [31:0]       dbg_ar_do,
  input  logic [31:0]       dbg_ar_di,
  input  logic              dbg_ar_done,
  output logic              ndmreset
);
  localparam int TW = $clog2(AR_TIMEOUT + 1);
  localparam logic [DMI_AW-1:0] A_D0  = DMI_AW'(7'h04);
  localparam logic [DMI_AW-1:0] A_DMC = DMI_AW'(7'h10);
  localparam logic [DMI_AW-1:0] A_DMS = DMI_AW'(7'h11);
  localparam logic [DMI_AW-1:0] A_ACS = DMI_AW'(7'h16);
  localparam logic [DMI_AW-1:0] A_CMD = DMI_AW'(7'h17);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t        state;
  logic          dmactive, resumeack;
  logic [31:0]   data0;
  logic [2:0]    cmderr;
  logic [TW-1:0] tmo;
  logic          acc, rd, wr, busy, busy_err, cmd_bad;
  logic [31:0]   dms, acs, rd_val;
  assign dmi_req_ready = ~dmi_rsp_valid;
  assign acc      = dmi_req_valid & dmi_req_ready;
  assign rd       = acc & (dmi_req_op == 2'd1);
  assign wr       = acc & (dmi_req_op == 2'd2);
  assign busy     = state == ACCESS;
  assign busy_err = busy & ((wr & (dmi_req_addr == A_CMD || dmi_req_addr == A_ACS || dmi_req_addr == A_D0)) |
                            (rd & dmi_req_addr == A_D0));
  assign cmd_bad  = dmi_req_data[31:24] != 8'd0 || dmi_req_data[22:20] != 3'd2 || dmi_req_data[18];
  assign dms      = {14'd0, {2{resumeack}}, 4'd0, {2{core_running}}, {2{core_halted}}, 1'b1, 3'd0, 4'd2};
  assign acs      = {19'd0, busy, 1'b0, cmderr, 4'd0, 4'd1};
  always_comb begin
    rd_val = dmi_req_addr == A_DMC ? {dbg_haltreq, 29'd0, ndmreset, dmactive} :
             dmi_req_addr == A_DMS ? dms :
             dmi_req_addr == A_ACS ? acs :
             (dmi_req_addr == A_D0 && !busy) ? data0 : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      dmi_rsp_valid <= 1'b0;
      dmi_rsp_data  <= '0;
      dbg_haltreq   <= 1'b0;
      dbg_resumereq <= 1'b0;
      ndmreset      <= 1'b0;
      dmactive      <= 1'b0;
      resumeack     <= 1'b0;
      data0         <= '0;
      cmderr        <= '0;
      tmo           <= '0;
      dbg_ar_en     <= 1'b0;
      dbg_ar_wr     <= 1'b0;
      dbg_ar_ad     <= '0;
      dbg_ar_do     <= '0;
    end else begin
      dmi_rsp_valid <= acc;
      dmi_rsp_data  <= rd ? rd_val : 32'd0;
      if (dbg_resumereq && core_resumeack) begin
        dbg_resumereq <= 1'b0;
        resumeack     <= 1'b1;
      end
      if (busy_err) begin
        if (cmderr == 3'd0) cmderr <= 3'd1;
      end else if (wr && dmi_req_addr == A_DMC) begin
        if (!dmi_req_data[0]) begin
          dbg_haltreq   <= 1'b0;
          dbg_resumereq <= 1'b0;
          ndmreset      <= 1'b0;
          dmactive      <= 1'b0;
          resumeack     <= 1'b0;
          data0         <= '0;
          cmderr        <= '0;
        end else begin
          dbg_haltreq <= dmi_req_data[31];
          ndmreset    <= dmi_req_data[1];
          dmactive    <= 1'b1;
          if (dmi_req_data[30] && !dmi_req_data[31]) begin
            dbg_resumereq <= 1'b1;
            resumeack     <= 1'b0;
          end
        end
      end else if (wr && dmi_req_addr == A_D0) begin
        data0 <= dmi_req_data;
      end else if (wr && dmi_req_addr == A_ACS) begin
        cmderr <= cmderr & ~dmi_req_data[10:8];
      end else if (wr && dmi_req_addr == A_CMD && cmderr == 3'd0) begin
        if (cmd_bad) cmderr <= 3'd2;
        else if (!core_halted) cmderr <= 3'd4;
        else if (dmi_req_data[17]) begin
          state     <= ACCESS;
          tmo       <= '0;
          dbg_ar_en <= 1'b1;
          dbg_ar_wr <= dmi_req_data[16];
          dbg_ar_ad <= dmi_req_data[15:0];
          dbg_ar_do <= data0;
        end
      end
      // completion and abort outrank a same-cycle busy error
      if (busy) begin
        if (dbg_ar_done) begin
          if (!dbg_ar_wr) data0 <= dbg_ar_di;
          state     <= IDLE;
          dbg_ar_en <= 1'b0;
        end else if (!core_halted) begin
          cmderr    <= 3'd4;
          state     <= IDLE;
          dbg_ar_en <= 1'b0;
        end else if (tmo == TW'(AR_TIMEOUT - 1)) begin
          cmderr    <= 3'd3;
          state     <= IDLE;
          dbg_ar_en <= 1'b0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
      // deactivating the DM overrides any access in flight
      if (wr && dmi_req_addr == A_DMC && !dmi_req_data[0]) begin
        state     <= IDLE;
        dbg_ar_en <= 1'b0;
        dbg_ar_wr <= 1'b0;
        dbg_ar_ad <= '0;
        dbg_ar_do <= '0;
        tmo       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dbg_module_ctrl.sv
// tb_dbg_module_ctrl: directed and randomized checks of the debug module against a register-level model
module tb_dbg_module_ctrl;
  logic        clk = 0, reset_n = 0;
  logic        dmi_req_valid = 0, dmi_req_ready;
  logic [6:0]  dmi_req_addr = 0;
  logic [1:0]  dmi_req_op = 0;
  logic [31:0] dmi_req_data = 0;
  logic        dmi_rsp_valid;
  logic [31:0] dmi_rsp_data;
  logic        dbg_haltreq, dbg_resumereq, core_resumeack = 0, core_running = 1, core_halted = 0;
  logic        dbg_ar_en, dbg_ar_wr, dbg_ar_done, ndmreset;
  logic [15:0] dbg_ar_ad;
  logic [31:0] dbg_ar_do, dbg_ar_di = 0;
  int          n_chk = 0, n_pass = 0;
  int          acc_cnt = 0, cur_len = 0, last_len = 0, lat = 0;
  logic        respond = 0, cap_wr = 0, stable = 0;
  logic [15:0] cap_ad = 0;
  logic [31:0] cap_do = 0;
  logic [31:0] m_data0;
  logic [2:0]  m_cmderr;
  logic        m_haltreq, m_ndm;

  dbg_module_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req_addr(dmi_req_addr),
    .dmi_req_op(dmi_req_op), .dmi_req_data(dmi_req_data),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data),
    .dbg_haltreq(dbg_haltreq), .dbg_resumereq(dbg_resumereq), .core_resumeack(core_resumeack),
    .core_running(core_running), .core_halted(core_halted),
    .dbg_ar_en(dbg_ar_en), .dbg_ar_wr(dbg_ar_wr), .dbg_ar_ad(dbg_ar_ad), .dbg_ar_do(dbg_ar_do),
    .dbg_ar_di(dbg_ar_di), .dbg_ar_done(dbg_ar_done), .ndmreset(ndmreset)
  );

  always #5 clk = ~clk;

  // core model: answers done after 'lat' enable cycles (0 = combinationally)
  assign dbg_ar_done = dbg_ar_en && respond && (cur_len == lat);

  always @(posedge clk) begin
    if (!reset_n) cur_len <= 0;
    else if (dbg_ar_en) begin
      if (cur_len == 0) begin
        cap_ad <= dbg_ar_ad; cap_wr <= dbg_ar_wr; cap_do <= dbg_ar_do; stable <= 1'b1;
      end else if (dbg_ar_ad != cap_ad || dbg_ar_wr != cap_wr || dbg_ar_do != cap_do) stable <= 1'b0;
      cur_len <= cur_len + 1;
    end else if (cur_len != 0) begin
      last_len <= cur_len; cur_len <= 0; acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic dmi(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    dmi_req_valid = 1; dmi_req_op = op; dmi_req_addr = a; dmi_req_data = d;
    @(posedge clk); #1;
    dmi_req_valid = 0; dmi_req_op = 0;
    chk("rsp_valid", {31'd0, dmi_rsp_valid}, 1);
    r = dmi_rsp_data;
    @(posedge clk); #1;
  endtask

  task automatic dwr(input logic [6:0] a, input logic [31:0] d);
    logic [31:0] r;
    dmi(2'd2, a, d, r);
  endtask

  task automatic drd(input string tag, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] r;
    dmi(2'd1, a, 32'd0, r);
    chk(tag, r, exp);
  endtask

  task automatic wait_acc(input int prev);
    for (int i = 0; i < 64 && acc_cnt == prev; i++) @(posedge clk);
    #1;
    chk("acc_done", {31'd0, acc_cnt != prev}, 1);
  endtask

  function automatic logic [31:0] exp_dms(input logic flag);
    return 32'h82 | (core_halted ? 32'h300 : 0) | (core_running ? 32'hc00 : 0) | (flag ? 32'h30000 : 0);
  endfunction

  function automatic logic [31:0] exp_acs();
    return ({29'd0, m_cmderr} << 8) | 32'd1;
  endfunction

  task automatic set_core(input logic h);
    @(negedge clk);
    core_halted = h; core_running = ~h;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int prev;
    #12;
    chk("rst_ready", {31'd0, dmi_req_ready}, 1);
    chk("rst_halt", {31'd0, dbg_haltreq}, 0);
    chk("rst_en", {31'd0, dbg_ar_en}, 0);
    chk("rst_rsp", {31'd0, dmi_rsp_valid}, 0);
    @(negedge clk) reset_n = 1;
    drd("rst_data0", 7'h04, 0);
    drd("rst_dmc", 7'h10, 0);

    set_core(1);
    dwr(7'h10, 32'h80000001);
    chk("haltreq", {31'd0, dbg_haltreq}, 1);
    drd("dms_halted", 7'h11, 32'h382);
    drd("dmc_rd", 7'h10, 32'h80000001);

    respond = 1; lat = 0; dbg_ar_di = 32'hDEADBEEF; prev = acc_cnt;
    dwr(7'h17, 32'h00221005);
    wait_acc(prev);
    chk("gpr_len", last_len, 1);
    chk("gpr_ad", {16'd0, cap_ad}, 32'h1005);
    chk("gpr_wr", {31'd0, cap_wr}, 0);
    drd("gpr_data0", 7'h04, 32'hDEADBEEF);
    drd("gpr_acs", 7'h16, 32'h1);

    dwr(7'h04, 32'h12345678);
    lat = 2; prev = acc_cnt;
    dwr(7'h17, 32'h002307b1);
    wait_acc(prev);
    chk("csr_wr", {31'd0, cap_wr}, 1);
    chk("csr_ad", {16'd0, cap_ad}, 32'h07b1);
    chk("csr_do", cap_do, 32'h12345678);
    chk("csr_len", last_len, 3);
    chk("csr_stable", {31'd0, stable}, 1);
    drd("csr_data0", 7'h04, 32'h12345678);

    set_core(0); prev = acc_cnt;
    dwr(7'h17, 32'h00221005);
    drd("err4", 7'h16, 32'h401);
    chk("err4_noacc", acc_cnt, prev);
    set_core(1);
    dwr(7'h16, 32'h700);
    drd("w1c", 7'h16, 32'h1);
    dwr(7'h17, 32'h00321005);
    drd("err2", 7'h16, 32'h201);
    dwr(7'h16, 32'h700);

    respond = 0; prev = acc_cnt;
    dwr(7'h17, 32'h00221005);
    drd("busy_bit", 7'h16, 32'h1001);
    wait_acc(prev);
    chk("tmo_len", last_len, 16);
    chk("tmo_en", {31'd0, dbg_ar_en}, 0);
    drd("err3", 7'h16, 32'h301);
    drd("tmo_data0", 7'h04, 32'h12345678);
    dwr(7'h16, 32'h700);

    respond = 1; lat = 6; dbg_ar_di = 32'hCAFEF00D; prev = acc_cnt;
    dwr(7'h17, 32'h00221005);
    dwr(7'h17, 32'h00221006);
    wait_acc(prev);
    chk("busy_len", last_len, 7);
    chk("busy_ad", {16'd0, cap_ad}, 32'h1005);
    drd("err1", 7'h16, 32'h101);
    drd("busy_data0", 7'h04, 32'hCAFEF00D);
    dwr(7'h16, 32'h700);

    respond = 0; prev = acc_cnt;
    dwr(7'h17, 32'h00221005);
    set_core(0);
    wait_acc(prev);
    drd("halt_fall", 7'h16, 32'h401);
    dwr(7'h16, 32'h700);

    set_core(1);
    dwr(7'h10, 32'h40000001);
    chk("resume_set", {31'd0, dbg_resumereq}, 1);
    chk("resume_nohalt", {31'd0, dbg_haltreq}, 0);
    drd("dms_noack", 7'h11, exp_dms(0));
    repeat (3) @(posedge clk);
    #1 chk("resume_hold", {31'd0, dbg_resumereq}, 1);
    @(negedge clk) core_resumeack = 1;
    @(negedge clk) core_resumeack = 0;
    chk("resume_clr", {31'd0, dbg_resumereq}, 0);
    set_core(0);
    drd("dms_ack", 7'h11, 32'h30c82);
    dwr(7'h10, 32'hC0000001);
    chk("both_halt", {31'd0, dbg_haltreq}, 1);
    chk("both_noresume", {31'd0, dbg_resumereq}, 0);
    drd("dms_keep", 7'h11, 32'h30c82);

    dwr(7'h04, 32'hA5A5A5A5);
    dwr(7'h10, 32'h0);
    chk("deact_halt", {31'd0, dbg_haltreq}, 0);
    drd("deact_data0", 7'h04, 0);
    drd("deact_dmc", 7'h10, 0);
    drd("deact_dms", 7'h11, 32'hc82);
    dwr(7'h10, 32'h1);
    set_core(1);

    m_data0 = 0; m_cmderr = 0; m_haltreq = 0; m_ndm = 0;
    for (int it = 0; it < 150; it++) begin
      int sel;
      logic [31:0] d;
      sel = $urandom % 12;
      if (sel == 0) begin
        d = $urandom; dwr(7'h04, d); m_data0 = d;
      end else if (sel == 1) drd("r_data0", 7'h04, m_data0);
      else if (sel == 2) drd("r_dms", 7'h11, exp_dms(0));
      else if (sel == 3) drd("r_acs", 7'h16, exp_acs());
      else if (sel == 4) begin
        d = $urandom; dwr(7'h16, d); m_cmderr = m_cmderr & ~d[10:8];
      end else if (sel == 5) begin
        m_haltreq = 1'($urandom); m_ndm = 1'($urandom);
        dwr(7'h10, ({31'd0, m_haltreq} << 31) | ({31'd0, m_ndm} << 1) | 32'd1);
        chk("r_haltreq", {31'd0, dbg_haltreq}, {31'd0, m_haltreq});
        chk("r_ndm", {31'd0, ndmreset}, {31'd0, m_ndm});
        drd("r_dmc", 7'h10, ({31'd0, m_haltreq} << 31) | ({31'd0, m_ndm} << 1) | 32'd1);
      end else if (sel == 6) set_core(($urandom % 4) != 0);
      else begin
        int kind, a;
        logic [15:0] regno;
        logic wbit, xfer, go;
        kind  = $urandom % 6;
        regno = kind < 2 ? 16'h1000 + 16'($urandom % 32) : 16'($urandom % 16'h1000);
        wbit  = 1'($urandom);
        xfer  = kind != 4;
        d = 32'h00200000 | ({31'd0, xfer} << 17) | ({31'd0, wbit} << 16) | {16'd0, regno};
        if (kind == 5) begin
          a = $urandom % 3;
          if (a == 0) d = d | ((1 + ($urandom % 255)) << 24);
          else if (a == 1) begin
            a = $urandom % 7;
            if (a >= 2) a++;
            d = (d & ~32'h00700000) | (a << 20);
          end else d = d | 32'h00040000;
        end
        respond = ($urandom % 6) != 0; lat = $urandom % 5; dbg_ar_di = $urandom;
        go = m_cmderr == 0 && kind != 5 && core_halted && xfer;
        prev = acc_cnt;
        dwr(7'h17, d);
        if (go) begin
          wait_acc(prev);
          chk("r_ad", {16'd0, cap_ad}, {16'd0, regno});
          chk("r_wr", {31'd0, cap_wr}, {31'd0, wbit});
          chk("r_do", cap_do, m_data0);
          chk("r_len", last_len, respond ? lat + 1 : 16);
          chk("r_stable", {31'd0, stable}, 1);
          if (!respond) m_cmderr = 3;
          else if (!wbit) m_data0 = dbg_ar_di;
        end else begin
          if (m_cmderr == 0 && kind == 5) m_cmderr = 2;
          else if (m_cmderr == 0 && !core_halted) m_cmderr = 4;
          repeat (2) @(posedge clk);
          #1;
          chk("r_noacc", acc_cnt, prev);
          chk("r_noen", {31'd0, dbg_ar_en}, 0);
        end
      end
    end

    set_core(1);
    dwr(7'h16, 32'h700);
    dwr(7'h04, 32'h55);
    dwr(7'h10, 32'h80000001);
    respond = 0;
    dwr(7'h17, 32'h00221005);
    chk("pre_rst_en", {31'd0, dbg_ar_en}, 1);
    #2 reset_n = 0;
    #1;
    chk("arst_en", {31'd0, dbg_ar_en}, 0);
    chk("arst_halt", {31'd0, dbg_haltreq}, 0);
    chk("arst_resume", {31'd0, dbg_resumereq}, 0);
    chk("arst_ready", {31'd0, dmi_req_ready}, 1);
    @(negedge clk) reset_n = 1;
    drd("arst_data0", 7'h04, 0);
    drd("arst_acs", 7'h16, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
